// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared bus definitions for the D_Cache memory-side request path.
// Holds the bus command encoding, data width, request payload and
// tag-table entry types used by dcache_mem_ctrl and its request FIFO.
package dcache_mem_ctrl_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NUM_MEM_TAGS = 16;
   localparam int unsigned TAG_W        = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   typedef struct packed {
      BUS_COMMAND        cmd;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   data;
   } mem_req_t;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   addr;
   } tag_entry_t;

endpackage

// File: rtl/dcache_mem_ctrl_req_fifo.sv
// Request FIFO between D_Cache and the memory port.
// Ports: clk, rst (async active-low), push/wr_req write side,
// pop/head_c read side (head_c is the current head, valid when !empty_c),
// full_c/empty_c combinational status from the registered pointers.
module req_fifo
   import dcache_mem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  mem_req_t wr_req,
   output mem_req_t head_c,
   output logic     full_c,
   output logic     empty_c
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   mem_req_t         mem [DEPTH];

   // Pointers carry an extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Payload storage needs no reset; it is only read when non-empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[IDX_W-1:0]] <= wr_req;
   end

   assign head_c  = mem[rd_ptr[IDX_W-1:0]];
   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Memory-side request controller downstream of D_Cache.
// Buffers cache requests (req_*) in a FIFO, issues the head to the tagged
// memory port (mem_*) retrying on rejection, tracks accepted loads by tag
// and returns fills (fill_*) when tagged data comes back.
// outstanding counts tracked loads; tag_error is a sticky protocol flag.
// req_ready and mem_command/mem_addr/mem_data are combinational.
module dcache_mem_ctrl
   import dcache_mem_ctrl_pkg::*;
#(
   parameter int unsigned REQ_DEPTH       = 4,
   parameter int unsigned MAX_OUTSTANDING = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  BUS_COMMAND       req_command,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_data,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_data,
   output BUS_COMMAND       mem_command,
   input  logic [TAG_W-1:0] mem_response,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [TAG_W-1:0] mem_tag,
   output logic             fill_valid,
   output logic [XLEN-1:0]  fill_addr,
   output logic [XLEN-1:0]  fill_data,
   output logic [TAG_W-1:0] outstanding,
   output logic             tag_error
);

   mem_req_t   head;
   mem_req_t   wr_req;
   logic       full;
   logic       empty;
   logic       push;
   logic       issue;
   logic       accept;
   logic       alloc;
   logic       ret_hit;
   logic       ret_miss;
   logic       dup_alloc;
   tag_entry_t tag_tbl [NUM_MEM_TAGS];

   assign req_ready = !full;
   assign push      = req_valid && req_ready && (req_command != BUS_NONE);
   assign wr_req    = {req_command, req_addr, req_data};

   req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (accept),
      .wr_req  (wr_req),
      .head_c  (head),
      .full_c  (full),
      .empty_c (empty)
   );

   // Issue the head unless it is a load and the tag table is saturated.
   always_comb begin
      issue       = 1'b0;
      mem_command = BUS_NONE;
      mem_addr    = '0;
      mem_data    = '0;
      if (!empty && ((head.cmd == BUS_STORE) ||
                     (outstanding < TAG_W'(MAX_OUTSTANDING)))) begin
         issue       = 1'b1;
         mem_command = head.cmd;
         mem_addr    = head.addr;
         mem_data    = head.data;
      end
   end

   assign accept    = issue && (mem_response != '0);
   assign alloc     = accept && (head.cmd == BUS_LOAD);
   assign ret_hit   = (mem_tag != '0) &&  tag_tbl[mem_tag].valid;
   assign ret_miss  = (mem_tag != '0) && !tag_tbl[mem_tag].valid;
   // Reusing a tag is legal only when that same tag is being freed now.
   assign dup_alloc = alloc && tag_tbl[mem_response].valid &&
                      !(ret_hit && (mem_tag == mem_response));

   // Tag table, fill return and bookkeeping; allocate is written after
   // free so a same-tag free+allocate leaves the new entry valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_MEM_TAGS; i++) tag_tbl[i] <= '0;
         outstanding <= '0;
         fill_valid  <= 1'b0;
         fill_addr   <= '0;
         fill_data   <= '0;
         tag_error   <= 1'b0;
      end else begin
         fill_valid <= ret_hit;
         if (ret_hit) begin
            fill_addr              <= tag_tbl[mem_tag].addr;
            fill_data              <= mem_rdata;
            tag_tbl[mem_tag].valid <= 1'b0;
         end
         if (alloc) tag_tbl[mem_response] <= {1'b1, head.addr};
         if (ret_miss || dup_alloc) tag_error <= 1'b1;
         case ({alloc, ret_hit})
            2'b10:   outstanding <= outstanding + TAG_W'(1);
            2'b01:   outstanding <= outstanding - TAG_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Self-checking bench for dcache_mem_ctrl: issue and fill scoreboards
// plus directed checks of handshake, flow control and tag bookkeeping.
module tb_dcache_mem_ctrl;
   import dcache_mem_ctrl_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid;
   logic             req_ready;
   BUS_COMMAND       req_command;
   logic [XLEN-1:0]  req_addr;
   logic [XLEN-1:0]  req_data;
   logic [XLEN-1:0]  mem_addr;
   logic [XLEN-1:0]  mem_data;
   BUS_COMMAND       mem_command;
   logic [TAG_W-1:0] mem_response;
   logic [XLEN-1:0]  mem_rdata;
   logic [TAG_W-1:0] mem_tag;
   logic             fill_valid;
   logic [XLEN-1:0]  fill_addr;
   logic [XLEN-1:0]  fill_data;
   logic [TAG_W-1:0] outstanding;
   logic             tag_error;

   int n_checks = 0;
   int n_fails  = 0;
   mem_req_t q_iss  [$];
   mem_req_t q_fill [$];

   always #5 clk = ~clk;

   dcache_mem_ctrl #(.REQ_DEPTH(4), .MAX_OUTSTANDING(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_command  (req_command),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_command  (mem_command),
      .mem_response (mem_response),
      .mem_rdata    (mem_rdata),
      .mem_tag      (mem_tag),
      .fill_valid   (fill_valid),
      .fill_addr    (fill_addr),
      .fill_data    (fill_data),
      .outstanding  (outstanding),
      .tag_error    (tag_error)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic mem_req_t mk(input BUS_COMMAND c, input logic [31:0] a, input logic [31:0] d);
      mem_req_t r;
      r.cmd  = c;
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   // Present one request for a cycle; it must be taken (FIFO not full).
   task automatic push_one(input BUS_COMMAND c, input logic [31:0] a, input logic [31:0] d);
      req_valid   = 1'b1;
      req_command = c;
      req_addr    = a;
      req_data    = d;
      sample();
      check_eq("push_ready", 32'(req_ready), 32'd1);
      q_iss.push_back(mk(c, a, d));
      step();
      req_valid   = 1'b0;
      req_command = BUS_NONE;
   endtask

   // Scoreboard monitor: accepted issues and fills, checked mid-cycle.
   always @(negedge clk) begin : mon
      mem_req_t e;
      if (rst && (mem_command != BUS_NONE) && (mem_response != 4'd0)) begin
         if (q_iss.size() == 0) check_eq("iss_unexpected", 32'(mem_command), 32'(BUS_NONE));
         else begin
            e = q_iss.pop_front();
            check_eq("iss_cmd", 32'(mem_command), 32'(e.cmd));
            check_eq("iss_addr", mem_addr, e.addr);
            check_eq("iss_data", mem_data, e.data);
         end
      end
      if (fill_valid) begin
         if (q_fill.size() == 0) check_eq("fill_unexpected", 32'(fill_valid), 32'd0);
         else begin
            e = q_fill.pop_front();
            check_eq("fill_addr", fill_addr, e.addr);
            check_eq("fill_data", fill_data, e.data);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_valid = 1'b0; req_command = BUS_NONE; req_addr = '0; req_data = '0;
      mem_response = '0; mem_rdata = '0; mem_tag = '0;
      repeat (2) step();
      sample();
      check_eq("rst_ready", 32'(req_ready), 32'd1);
      check_eq("rst_cmd", 32'(mem_command), 32'(BUS_NONE));
      check_eq("rst_maddr", mem_addr, 32'd0);
      check_eq("rst_outst", 32'(outstanding), 32'd0);
      check_eq("rst_fvalid", 32'(fill_valid), 32'd0);
      check_eq("rst_faddr", fill_addr, 32'd0);
      check_eq("rst_fdata", fill_data, 32'd0);
      check_eq("rst_terr", 32'(tag_error), 32'd0);
      step();
      rst = 1'b1;

      // Single load, accepted with tag 3, then returned.
      push_one(BUS_LOAD, 32'h100, 32'h0);
      mem_response = 4'd3;
      sample();
      check_eq("t1_cmd", 32'(mem_command), 32'(BUS_LOAD));
      check_eq("t1_addr", mem_addr, 32'h100);
      check_eq("t1_outst0", 32'(outstanding), 32'd0);
      step();
      mem_response = 4'd0;
      sample();
      check_eq("t1_outst1", 32'(outstanding), 32'd1);
      check_eq("t1_idle", 32'(mem_command), 32'(BUS_NONE));
      step();
      mem_tag = 4'd3; mem_rdata = 32'hDEADBEEF;
      q_fill.push_back(mk(BUS_LOAD, 32'h100, 32'hDEADBEEF));
      step();
      mem_tag = 4'd0;
      sample();
      check_eq("t1_fvalid", 32'(fill_valid), 32'd1);
      check_eq("t1_outst2", 32'(outstanding), 32'd0);
      step();
      sample();
      check_eq("t1_pulse", 32'(fill_valid), 32'd0);
      step();

      // Store rejected twice, then accepted with tag 5.
      push_one(BUS_STORE, 32'h40, 32'h55);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) mem_response = 4'd5;
         sample();
         check_eq("t2_cmd", 32'(mem_command), 32'(BUS_STORE));
         check_eq("t2_addr", mem_addr, 32'h40);
         check_eq("t2_data", mem_data, 32'h55);
         step();
      end
      mem_response = 4'd0;
      sample();
      check_eq("t2_idle", 32'(mem_command), 32'(BUS_NONE));
      check_eq("t2_outst", 32'(outstanding), 32'd0);
      check_eq("t2_nofill", 32'(fill_valid), 32'd0);
      step();

      // Fill the FIFO under rejection, then drain in order.
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1; req_command = BUS_STORE;
         req_addr = 32'(32'h200 + k * 4); req_data = 32'(k + 1);
         sample();
         check_eq("t3_ready", 32'(req_ready), 32'(k < 4));
         if (k < 4) q_iss.push_back(mk(BUS_STORE, req_addr, req_data));
         step();
      end
      mem_response = 4'd1;
      sample();
      check_eq("t3_still_full", 32'(req_ready), 32'd0);
      step();
      sample();
      check_eq("t3_freed", 32'(req_ready), 32'd1);
      q_iss.push_back(mk(BUS_STORE, req_addr, req_data));
      step();
      req_valid = 1'b0; req_command = BUS_NONE;
      for (int k = 0; k < 20 && q_iss.size() != 0; k++) begin
         sample();
         step();
      end
      check_eq("t3_drain", 32'(q_iss.size()), 32'd0);
      mem_response = 4'd0;

      // Saturate the tag table with tags 1..15.
      for (int i = 1; i <= 15; i++) begin
         push_one(BUS_LOAD, 32'(32'h1000 + i * 4), 32'h0);
         mem_response = 4'(i);
         sample();
         step();
         mem_response = 4'd0;
      end
      sample();
      check_eq("t4_outst15", 32'(outstanding), 32'd15);
      step();
      push_one(BUS_LOAD, 32'h2000, 32'h0);
      sample();
      check_eq("t4_stall_cmd", 32'(mem_command), 32'(BUS_NONE));
      check_eq("t4_stall_addr", mem_addr, 32'd0);
      step();
      mem_tag = 4'd7; mem_rdata = 32'h77;
      q_fill.push_back(mk(BUS_LOAD, 32'h101C, 32'h77));
      sample();
      check_eq("t4_stall2", 32'(mem_command), 32'(BUS_NONE));
      step();
      mem_tag = 4'd0; mem_response = 4'd7;
      sample();
      check_eq("t4_outst14", 32'(outstanding), 32'd14);
      check_eq("t4_issue", 32'(mem_command), 32'(BUS_LOAD));
      check_eq("t4_issue_addr", mem_addr, 32'h2000);
      step();
      mem_response = 4'd0;
      sample();
      check_eq("t4_outst15b", 32'(outstanding), 32'd15);
      step();

      // Free tag 1, then same-cycle return/accept on tag 9.
      mem_tag = 4'd1; mem_rdata = 32'h11;
      q_fill.push_back(mk(BUS_LOAD, 32'h1004, 32'h11));
      step();
      mem_tag = 4'd0;
      sample();
      check_eq("t5_outst14", 32'(outstanding), 32'd14);
      step();
      push_one(BUS_LOAD, 32'h3000, 32'h0);
      mem_response = 4'd9; mem_tag = 4'd9; mem_rdata = 32'h99;
      q_fill.push_back(mk(BUS_LOAD, 32'h1024, 32'h99));
      step();
      mem_response = 4'd0; mem_tag = 4'd0;
      sample();
      check_eq("t5_fvalid", 32'(fill_valid), 32'd1);
      check_eq("t5_terr0", 32'(tag_error), 32'd0);
      check_eq("t5_outst_same", 32'(outstanding), 32'd14);
      step();
      mem_tag = 4'd9; mem_rdata = 32'hAA;
      q_fill.push_back(mk(BUS_LOAD, 32'h3000, 32'hAA));
      step();
      mem_tag = 4'd0;
      sample();
      check_eq("t5_outst13", 32'(outstanding), 32'd13);
      check_eq("t5_terr1", 32'(tag_error), 32'd0);
      step();
      mem_tag = 4'd9;
      step();
      mem_tag = 4'd0;
      sample();
      check_eq("t5_spur_fill", 32'(fill_valid), 32'd0);
      check_eq("t5_spur_err", 32'(tag_error), 32'd1);
      check_eq("t5_spur_outst", 32'(outstanding), 32'd13);
      repeat (2) step();
      sample();
      check_eq("t5_sticky", 32'(tag_error), 32'd1);
      step();

      // Asynchronous reset with loads outstanding and queued.
      push_one(BUS_LOAD, 32'h4000, 32'h0);
      push_one(BUS_LOAD, 32'h4004, 32'h0);
      sample();
      check_eq("t6_pre_cmd", 32'(mem_command), 32'(BUS_LOAD));
      rst = 1'b0;
      #1;
      check_eq("t6_outst", 32'(outstanding), 32'd0);
      check_eq("t6_terr", 32'(tag_error), 32'd0);
      check_eq("t6_cmd", 32'(mem_command), 32'(BUS_NONE));
      check_eq("t6_ready", 32'(req_ready), 32'd1);
      check_eq("t6_fvalid", 32'(fill_valid), 32'd0);
      q_iss.delete();
      step();
      rst = 1'b1;
      step();
      mem_tag = 4'd2; mem_rdata = 32'h22;
      step();
      mem_tag = 4'd0;
      sample();
      check_eq("t6_nofill", 32'(fill_valid), 32'd0);
      check_eq("t6_err", 32'(tag_error), 32'd1);
      step();
      sample();
      check_eq("end_fill_q", 32'(q_fill.size()), 32'd0);
      check_eq("end_iss_q", 32'(q_iss.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
